// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of NREQ reservation-station ops
// onto one shared ALU through an EX register and a WB result register.
module alu_issue_arbiter #(
  parameter int BITWIDTH = 32,
  parameter int NREQ     = 4,
  parameter int TAGW     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*BITWIDTH-1:0] req_A,
  input  logic [NREQ*BITWIDTH-1:0] req_B,
  input  logic [NREQ*3-1:0]        req_op,
  input  logic [NREQ*TAGW-1:0]     req_tag,
  output logic [BITWIDTH-1:0]      alu_A,
  output logic [BITWIDTH-1:0]      alu_B,
  output logic [2:0]               alu_ctrl,
  output logic                     alu_en,
  input  logic [BITWIDTH-1:0]      alu_result,
  input  logic                     alu_zero,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [BITWIDTH-1:0]      res_data,
  output logic [TAGW-1:0]          res_tag,
  output logic                     res_zero,
  output logic                     busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [BITWIDTH-1:0] a;
    logic [BITWIDTH-1:0] b;
    logic [2:0]          op;
    logic [TAGW-1:0]     tag;
  } ex_op_t;

  logic          ex_valid;
  ex_op_t        ex_q;
  ex_op_t        sel;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   cand;
  logic          hit;
  logic          grant;
  logic          wb_take;
  logic          ex_adv;

  assign wb_take = ~res_valid | res_ready;
  assign ex_adv  = ~ex_valid | wb_take;

  // First valid requester at or after rr_ptr, wrapping at NREQ-1.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ))
        cand = cand - (PW+1)'(NREQ);
      if (!hit && req_valid[cand[PW-1:0]]) begin
        hit     = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  assign grant = hit & ex_adv & ~flush & rst_n;

  // One-hot grant only while the EX slot can take a new op.
  always_comb begin
    req_ready = '0;
    if (grant)
      req_ready = NREQ'(1) << gnt_idx;
  end

  // Payload of the granted requester.
  always_comb begin
    sel.a   = req_A[int'(gnt_idx)*BITWIDTH +: BITWIDTH];
    sel.b   = req_B[int'(gnt_idx)*BITWIDTH +: BITWIDTH];
    sel.op  = req_op[int'(gnt_idx)*3 +: 3];
    sel.tag = req_tag[int'(gnt_idx)*TAGW +: TAGW];
  end

  // Round-robin pointer moves past the winner; holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (grant)
      rr_ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  // EX stage: load on grant, empty when it drains, squash on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (grant) begin
      ex_valid <= 1'b1;
      ex_q     <= sel;
    end else if (ex_adv) begin
      ex_valid <= 1'b0;
    end
  end

  // WB stage: capture ALU output, hold it until the bus accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_zero  <= 1'b0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (wb_take && ex_valid) begin
      res_valid <= 1'b1;
      res_data  <= alu_result;
      res_tag   <= ex_q.tag;
      res_zero  <= alu_zero;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // ALU inputs are forced to zero while idle so they do not toggle.
  always_comb begin
    alu_en   = ex_valid;
    alu_A    = ex_valid ? ex_q.a  : '0;
    alu_B    = ex_valid ? ex_q.b  : '0;
    alu_ctrl = ex_valid ? ex_q.op : '0;
  end

  assign busy = ex_valid | res_valid;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: random requesters, behavioural ALU, and a
// scoreboard of expected results checked by a negedge monitor.
module tb_alu_issue_arbiter;

  localparam int BW = 32;
  localparam int NR = 4;
  localparam int TW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*BW-1:0] req_A;
  logic [NR*BW-1:0] req_B;
  logic [NR*3-1:0] req_op;
  logic [NR*TW-1:0] req_tag;
  logic [BW-1:0]   alu_A;
  logic [BW-1:0]   alu_B;
  logic [2:0]      alu_ctrl;
  logic            alu_en;
  logic [BW-1:0]   alu_result;
  logic            alu_zero;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [BW-1:0]   res_data;
  logic [TW-1:0]   res_tag;
  logic            res_zero;
  logic            busy;

  logic [BW-1:0] a_r [NR];
  logic [BW-1:0] b_r [NR];
  logic [2:0]    op_r [NR];
  logic [TW-1:0] tag_r [NR];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [BW-1:0] d;
    logic [TW-1:0] t;
    logic          z;
    int            c;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            ptr = 0;
  int            cyc = 0;
  int            jj;
  logic [NR-1:0] acc = '0;
  logic [NR-1:0] er;
  logic          rv;
  logic          hold = 1'b0;
  logic [BW+TW:0] hv;

  alu_issue_arbiter #(.BITWIDTH(BW), .NREQ(NR), .TAGW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_op(req_op), .req_tag(req_tag),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ctrl(alu_ctrl), .alu_en(alu_en),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_zero(res_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] alu_f(input logic [BW-1:0] a,
                                          input logic [BW-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return $signed(a) >>> b[4:0];
      3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd6: return a >> b[4:0];
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_A, alu_B, alu_ctrl);
    alu_zero   = (alu_result == '0);
  end

  always_comb begin
    req_A = '0;
    req_B = '0;
    req_op = '0;
    req_tag = '0;
    for (int i = 0; i < NR; i++) begin
      req_A[i*BW +: BW]   = a_r[i];
      req_B[i*BW +: BW]   = b_r[i];
      req_op[i*3 +: 3]    = op_r[i];
      req_tag[i*TW +: TW] = tag_r[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare against the pipeline model, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      ptr  = 0;
      hold = 1'b0;
      acc  = '0;
    end else begin
      er = '0;
      if ((q.size() < 2 || res_ready) && !flush)
        for (int k = 0; k < NR; k++) begin
          jj = (ptr + k) % NR;
          if (req_valid[jj] && er == '0)
            er[jj] = 1'b1;
        end
      chk("req_ready", 64'(req_ready), 64'(er));
      rv = (q.size() > 0) && (cyc - q[0].c >= 2);
      chk("res_valid", 64'(res_valid), 64'(rv));
      chk("busy", 64'(busy), 64'(q.size() > 0));
      chk("alu_en", 64'(alu_en), 64'(q.size() > (rv ? 1 : 0)));
      if (!alu_en)
        chk("alu_idle", 64'(alu_A | alu_B | BW'(alu_ctrl)), 64'(0));
      if (hold)
        chk("res_hold", 64'({res_data, res_tag, res_zero}), 64'(hv));
      if (res_valid && res_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("res_data", 64'(res_data), 64'(e.d));
        chk("res_tag", 64'(res_tag), 64'(e.t));
        chk("res_zero", 64'(res_zero), 64'(e.z));
      end
      hold = res_valid && !res_ready && !flush;
      hv   = {res_data, res_tag, res_zero};
      acc  = req_valid & req_ready;
      if (flush)
        q.delete();
      else
        for (int i = 0; i < NR; i++)
          if (acc[i]) begin
            e.d = alu_f(a_r[i], b_r[i], op_r[i]);
            e.t = tag_r[i];
            e.z = (e.d == '0);
            e.c = cyc;
            q.push_back(e);
            ptr = (i + 1) % NR;
          end
    end
    cyc++;
  end

  task automatic put(input int i, input logic [BW-1:0] a,
                     input logic [BW-1:0] b, input logic [2:0] op,
                     input logic [TW-1:0] t);
    req_valid[i] = 1'b1;
    a_r[i] = a;
    b_r[i] = b;
    op_r[i] = op;
    tag_r[i] = t;
  endtask

  task automatic cycle(input int pv, input int pr, input int pf);
    logic [BW-1:0] a;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i])
        req_valid[i] = 1'b0;
      if (!req_valid[i] && int'($urandom_range(99)) < pv) begin
        a = $urandom;
        put(i, a, ($urandom_range(3) == 0) ? a : $urandom,
            3'($urandom_range(7)), TW'($urandom));
      end
    end
    res_ready = int'($urandom_range(99)) < pr;
    flush     = int'($urandom_range(99)) < pf;
  endtask

  task automatic directed(input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input logic [2:0] op, input logic [TW-1:0] t,
                          input logic [BW-1:0] ed, input logic ez);
    repeat (8) cycle(0, 100, 0);
    put(0, a, b, op, t);
    @(negedge clk);
    #1;
    chk("dir_grant", 64'(req_ready), 64'(1));
    cycle(0, 100, 0);
    @(negedge clk);
    cycle(0, 100, 0);
    @(negedge clk);
    #1;
    chk("dir_valid", 64'(res_valid), 64'(1));
    chk("dir_data", 64'(res_data), 64'(ed));
    chk("dir_tag", 64'(res_tag), 64'(t));
    chk("dir_zero", 64'(res_zero), 64'(ez));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) put(i, BW'(i+1), BW'(i), 3'd0, TW'(i));
    @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_alu_en", 64'(alu_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_res", 64'({res_data, res_tag, res_zero}), 64'(0));
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    directed(32'd5, 32'd3, 3'd0, 5'd7, 32'd8, 1'b0);
    directed(32'd9, 32'd9, 3'd1, 5'd3, 32'd0, 1'b1);
    directed(32'd0, 32'd1, 3'd1, 5'd4, 32'hFFFF_FFFF, 1'b0);

    repeat (20) cycle(100, 100, 0);
    repeat (4) cycle(100, 0, 0);
    repeat (6) cycle(100, 100, 0);
    repeat (300) cycle(50, 60, 0);
    repeat (300) cycle(70, 70, 8);

    repeat (5) cycle(100, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", 64'(res_valid), 64'(0));
    chk("arst_ready", 64'(req_ready), 64'(0));
    chk("arst_alu_en", 64'(alu_en), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("arst_first_grant", 64'(req_ready), 64'(1));

    repeat (200) cycle(50, 50, 3);
    repeat (12) cycle(0, 100, 0);
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
